// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
//   Program-counter unit placed between instruction fetch and the
//   branch-resolve / exception logic. It holds the PC register and picks the
//   next PC from these sources: exception vector, resolved branch, jump/call,
//   return (from the return-address stack), sequential increment, or hold.
//   A small BOOT/RUN/BUBBLE FSM produces the valid side of a valid/ready
//   handshake toward fetch.
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous reset, active low
//   stall        in   hold PC (pipeline hazard)
//   fetch_ready  in   fetch accepts the current pc this cycle
//   br_taken     in   resolved taken branch (1-cycle pulse)
//   br_target    in   branch destination
//   jmp          in   unconditional jump (1-cycle pulse)
//   call         in   with jmp: also push the return address
//   jmp_target   in   jump/call destination
//   ret          in   return: pop the RAS into the PC
//   exc          in   exception request (1-cycle pulse)
//   pc           out  current fetch address
//   pc_plus      out  pc + INC, wraps modulo 2^WIDTH
//   pc_valid     out  pc is a valid fetch request
//   ras_empty    out  RAS holds no entries
//   ras_full     out  RAS holds RAS_DEPTH entries
//   ras_err      out  1-cycle pulse: push on full or pop on empty
// ---------------------------------------------------------------------------
module pc_unit #(
    parameter int unsigned      WIDTH      = 16,
    parameter int unsigned      INC        = 4,
    parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(32'h0000_0000),
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h0000_0008),
    parameter int unsigned      RAS_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             fetch_ready,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jmp,
    input  logic             call,
    input  logic [WIDTH-1:0] jmp_target,
    input  logic             ret,
    input  logic             exc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             pc_valid,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_BUBBLE = 2'd2
    } state_t;

    // Registers
    state_t           r_state;
    logic             r_pc_valid;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0] r_top;      // index of the current top-of-stack entry
    logic [CNT_W-1:0] r_count;
    logic             r_ras_err;

    // Combinational
    logic [WIDTH-1:0] w_pc_plus;
    logic [WIDTH-1:0] w_pc_next;
    logic [PTR_W-1:0] w_push_ptr;
    logic             w_accept;
    logic             w_redirect;
    logic             w_push;
    logic             w_pop;
    logic             w_err;
    logic             w_empty;
    logic             w_full;

    assign w_pc_plus  = r_pc + WIDTH'(INC);
    assign w_push_ptr = r_top + PTR_W'(1);
    assign w_empty    = (r_count == {CNT_W{1'b0}});
    assign w_full     = (r_count == DEPTH_C);
    assign w_accept   = r_pc_valid & fetch_ready & ~stall;

    // Next-PC selection; only the winning source raises RAS side effects.
    always_comb begin
        w_pc_next  = r_pc;
        w_redirect = 1'b0;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_err      = 1'b0;
        if (exc) begin
            w_pc_next  = EXC_VECTOR;
            w_redirect = 1'b1;
        end else if (br_taken) begin
            w_pc_next  = br_target;
            w_redirect = 1'b1;
        end else if (jmp) begin
            w_pc_next  = jmp_target;
            w_redirect = 1'b1;
            if (call) begin
                // A call pushes even when full: the oldest entry is overwritten.
                w_push = 1'b1;
                w_err  = w_full;
            end else begin
                w_push = 1'b0;
            end
        end else if (ret) begin
            w_redirect = 1'b1;
            if (!w_empty) begin
                w_pc_next = r_ras[r_top];
                w_pop     = 1'b1;
            end else begin
                // Underflow falls through to the sequential address.
                w_pc_next = w_pc_plus;
                w_err     = 1'b1;
            end
        end else if (w_accept) begin
            w_pc_next = w_pc_plus;
        end else begin
            w_pc_next = r_pc;
        end
    end

    // PC register, return-address stack and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_top     <= {PTR_W{1'b0}};
            r_count   <= {CNT_W{1'b0}};
            r_ras_err <= 1'b0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                r_ras[i] <= {WIDTH{1'b0}};
            end
        end else begin
            r_pc      <= w_pc_next;
            r_ras_err <= w_err;
            if (w_push) begin
                r_ras[w_push_ptr] <= w_pc_plus;
                r_top             <= w_push_ptr;
                if (!w_full) begin
                    r_count <= r_count + CNT_W'(1);
                end else begin
                    r_count <= r_count;
                end
            end else if (w_pop) begin
                r_top   <= r_top - PTR_W'(1);
                r_count <= r_count - CNT_W'(1);
            end else begin
                r_top   <= r_top;
                r_count <= r_count;
            end
        end
    end

    // Fetch-handshake FSM: BOOT and BUBBLE hide the pc for one cycle each.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_BOOT;
            r_pc_valid <= 1'b0;
        end else if (w_redirect) begin
            r_state    <= ST_BUBBLE;
            r_pc_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state    <= ST_RUN;
                    r_pc_valid <= 1'b1;
                end
                ST_RUN: begin
                    r_state    <= ST_RUN;
                    r_pc_valid <= 1'b1;
                end
                ST_BUBBLE: begin
                    r_state    <= ST_RUN;
                    r_pc_valid <= 1'b1;
                end
                default: begin
                    r_state    <= ST_BOOT;
                    r_pc_valid <= 1'b0;
                end
            endcase
        end
    end

    assign pc        = r_pc;
    assign pc_plus   = w_pc_plus;
    assign pc_valid  = r_pc_valid;
    assign ras_empty = w_empty;
    assign ras_full  = w_full;
    assign ras_err   = r_ras_err;

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit
//   Directed bench for pc_unit (default parameters: WIDTH 16, INC 4,
//   RESET_PC 0, EXC_VECTOR 'h0008, RAS_DEPTH 4). Stimulus pushes the
//   hand-computed expected state into a queue, tagged with the clock edge
//   after which it must hold; a separate monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        fetch_ready;
    logic        br_taken;
    logic [15:0] br_target;
    logic        jmp;
    logic        call;
    logic [15:0] jmp_target;
    logic        ret;
    logic        exc;
    logic [15:0] pc;
    logic [15:0] pc_plus;
    logic        pc_valid;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_err;

    pc_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .fetch_ready (fetch_ready),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jmp         (jmp),
        .call        (call),
        .jmp_target  (jmp_target),
        .ret         (ret),
        .exc         (exc),
        .pc          (pc),
        .pc_plus     (pc_plus),
        .pc_valid    (pc_valid),
        .ras_empty   (ras_empty),
        .ras_full    (ras_full),
        .ras_err     (ras_err)
    );

    typedef struct {
        int          cyc;
        logic [15:0] pc;
        logic [15:0] plus;
        logic        valid;
        logic        err;
        logic        empty;
        logic        full;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   edges  = 0;
    int   checks = 0;
    int   errors = 0;
    event chk_ev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges; expectations are tagged with this number.
    always @(posedge clk) edges <= edges + 1;

    task automatic cmp(input string nm, input string fld, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, req);
        end
    endtask

    // Pop and compare every expectation whose edge has been reached.
    task automatic drain();
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= edges) begin
            e = q.pop_front();
            if (e.cyc < edges) begin
                checks++;
                errors++;
                $display("FAIL %s: slot for edge %0d missed, now at edge %0d", e.nm, e.cyc, edges);
            end else begin
                cmp(e.nm, "pc",        pc,               e.pc);
                cmp(e.nm, "pc_plus",   pc_plus,          e.plus);
                cmp(e.nm, "pc_valid",  {15'd0, pc_valid},  {15'd0, e.valid});
                cmp(e.nm, "ras_err",   {15'd0, ras_err},   {15'd0, e.err});
                cmp(e.nm, "ras_empty", {15'd0, ras_empty}, {15'd0, e.empty});
                cmp(e.nm, "ras_full",  {15'd0, ras_full},  {15'd0, e.full});
            end
        end
    endtask

    // Monitor: sample away from the active edge.
    always @(negedge clk) drain();

    // Monitor: immediate sampling for asynchronous-reset checks.
    always @(chk_ev) drain();

    task automatic push_exp(input int ahead, input logic [15:0] p, input logic v, input logic er,
                            input logic em, input logic fu, input string nm);
        exp_t e;
        e.cyc   = edges + ahead;
        e.pc    = p;
        e.plus  = p + 16'd4;
        e.valid = v;
        e.err   = er;
        e.empty = em;
        e.full  = fu;
        e.nm    = nm;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect the state after the next edge, take that edge, drop the pulses.
    task automatic step(input logic [15:0] p, input logic v, input logic er,
                        input logic em, input logic fu, input string nm);
        push_exp(1, p, v, er, em, fu, nm);
        tick();
        br_taken = 1'b0;
        jmp      = 1'b0;
        call     = 1'b0;
        ret      = 1'b0;
        exc      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        fetch_ready = 1'b1;
        br_taken    = 1'b0;
        br_target   = 16'h0000;
        jmp         = 1'b0;
        call        = 1'b0;
        jmp_target  = 16'h0000;
        ret         = 1'b0;
        exc         = 1'b0;

        // Reset state
        tick();
        push_exp(0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, "reset");
        tick();
        rst_n = 1'b1;
        push_exp(0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, "boot");

        // 1: BOOT for one cycle, then sequential 0,4,8,12
        step(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, "run0");
        step(16'h0004, 1'b1, 1'b0, 1'b1, 1'b0, "seq4");
        step(16'h0008, 1'b1, 1'b0, 1'b1, 1'b0, "seq8");
        step(16'h000C, 1'b1, 1'b0, 1'b1, 1'b0, "seq12");

        // Exception brings pc back to 8 for the stall test
        exc = 1'b1;
        step(16'h0008, 1'b0, 1'b0, 1'b1, 1'b0, "exc_bubble");
        step(16'h0008, 1'b1, 1'b0, 1'b1, 1'b0, "exc_run");

        // 2: stall holds pc; a branch during stall still redirects
        stall = 1'b1;
        for (int i = 0; i < 3; i++) step(16'h0008, 1'b1, 1'b0, 1'b1, 1'b0, "stall_hold");
        br_taken  = 1'b1;
        br_target = 16'h0040;
        step(16'h0040, 1'b0, 1'b0, 1'b1, 1'b0, "br_in_stall");
        stall = 1'b0;
        step(16'h0040, 1'b1, 1'b0, 1'b1, 1'b0, "br_run");
        step(16'h0044, 1'b1, 1'b0, 1'b1, 1'b0, "br_seq");

        // One entry on the RAS so an unwanted push/pop becomes visible
        jmp = 1'b1; call = 1'b1; jmp_target = 16'h0010;
        step(16'h0010, 1'b0, 1'b0, 1'b0, 1'b0, "call_a");
        step(16'h0010, 1'b1, 1'b0, 1'b0, 1'b0, "call_a_run");

        // 3: exc beats br, jmp/call and ret; RAS untouched
        exc = 1'b1; br_taken = 1'b1; br_target = 16'h0098;
        jmp = 1'b1; call = 1'b1; jmp_target = 16'h0078; ret = 1'b1;
        step(16'h0008, 1'b0, 1'b0, 1'b0, 1'b0, "exc_prio");
        step(16'h0008, 1'b1, 1'b0, 1'b0, 1'b0, "exc_prio_run");
        ret = 1'b1;
        step(16'h0048, 1'b0, 1'b0, 1'b1, 1'b0, "ret_after_exc");
        step(16'h0048, 1'b1, 1'b0, 1'b1, 1'b0, "ret_run");

        // Branch beats a call: no push
        br_taken = 1'b1; br_target = 16'h0060;
        jmp = 1'b1; call = 1'b1; jmp_target = 16'h0070;
        step(16'h0060, 1'b0, 1'b0, 1'b1, 1'b0, "br_over_call");
        step(16'h0060, 1'b1, 1'b0, 1'b1, 1'b0, "br_over_call_run");

        // 4: calls from 'h10..'h50, overflow, then returns and underflow
        jmp = 1'b1; jmp_target = 16'h0010;
        step(16'h0010, 1'b0, 1'b0, 1'b1, 1'b0, "jmp10");
        step(16'h0010, 1'b1, 1'b0, 1'b1, 1'b0, "jmp10_run");
        for (int i = 1; i <= 4; i++) begin
            jmp = 1'b1; call = 1'b1; jmp_target = 16'(16 * (i + 1));
            step(16'(16 * (i + 1)), 1'b0, 1'b0, 1'b0, (i == 4), "call_n");
            step(16'(16 * (i + 1)), 1'b1, 1'b0, 1'b0, (i == 4), "call_n_run");
        end
        jmp = 1'b1; call = 1'b1; jmp_target = 16'h0060;
        step(16'h0060, 1'b0, 1'b1, 1'b0, 1'b1, "call5_overflow");
        step(16'h0060, 1'b1, 1'b0, 1'b0, 1'b1, "call5_run");
        for (int i = 0; i < 4; i++) begin
            ret = 1'b1;
            step(16'h0054 - 16'(16 * i), 1'b0, 1'b0, (i == 3), 1'b0, "ret_n");
            step(16'h0054 - 16'(16 * i), 1'b1, 1'b0, (i == 3), 1'b0, "ret_n_run");
        end
        ret = 1'b1;
        step(16'h0028, 1'b0, 1'b1, 1'b1, 1'b0, "ret_underflow");
        step(16'h0028, 1'b1, 1'b0, 1'b1, 1'b0, "ret_underflow_run");

        // 5: top address wraps to 0
        jmp = 1'b1; jmp_target = 16'hFFFC;
        step(16'hFFFC, 1'b0, 1'b0, 1'b1, 1'b0, "jmp_top");
        step(16'hFFFC, 1'b1, 1'b0, 1'b1, 1'b0, "top_run");
        step(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, "wrap");

        // 6: asynchronous reset during the bubble after a call
        jmp = 1'b1; call = 1'b1; jmp_target = 16'h0100;
        step(16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, "call_pre_rst");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        ret   = 1'b1;
        #1;
        push_exp(0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, "async_rst");
        -> chk_ev;
        tick();
        ret   = 1'b0;
        rst_n = 1'b1;
        step(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, "rerun0");
        step(16'h0004, 1'b1, 1'b0, 1'b1, 1'b0, "rerun4");

        tick();
        tick();
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL queue_drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
